// File: rtl/apb_bridge_pkg.sv
// Shared constants and state encoding for the APB3 master bridge.
package apb_bridge_pkg;

    localparam int APB_AW = 9;
    localparam int APB_DW = 8;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on pready; flags when the last allowed wait cycle is reached.
module apb_wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Command-to-APB3 master bridge for two slaves; slave chosen by the address MSB.
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int AW       = APB_AW,
    parameter int DW       = APB_DW,
    parameter int MAX_WAIT = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          transfer,
    input  logic          read_write,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [AW-1:0] apb_read_paddr,
    input  logic [DW-1:0] apb_write_data,
    output logic [DW-1:0] apb_read_data_out,
    output logic          xfer_done,
    output logic          xfer_err,
    output logic          psel1,
    output logic          psel2,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic          pready,
    input  logic [DW-1:0] prdata,
    input  logic          pslverr
);

    apb_state_e    r_state;
    logic          r_psel1;
    logic          r_psel2;
    logic          r_penable;
    logic          r_pwrite;
    logic [AW-1:0] r_paddr;
    logic [DW-1:0] r_pwdata;
    logic [DW-1:0] r_rdata;
    logic          r_done;
    logic          r_err;

    logic [AW-1:0] w_cmd_addr;
    logic          w_access;
    logic          w_complete;
    logic          w_latch;
    logic          w_expired;
    logic          w_tmr_clr;
    logic          w_tmr_en;

    assign w_cmd_addr = (read_write == WRITE) ? apb_write_paddr : apb_read_paddr;
    assign w_access   = (r_state == ST_ACCESS);
    assign w_complete = w_access && pready;
    assign w_latch    = transfer && ((r_state == ST_IDLE) || w_complete);
    assign w_tmr_clr  = (r_state == ST_SETUP);
    // Counter parks at its last value so the abort compare stays asserted.
    assign w_tmr_en   = w_access && !pready && !w_expired;

    apb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .i_clk     (pclk),
        .i_rst_n   (presetn),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state   <= ST_IDLE;
            r_psel1   <= 1'b0;
            r_psel2   <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_rdata   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_psel1   <= 1'b0;
                    r_psel2   <= 1'b0;
                    r_penable <= 1'b0;
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        r_done    <= 1'b1;
                        r_err     <= pslverr;
                        r_penable <= 1'b0;
                        r_psel1   <= 1'b0;
                        r_psel2   <= 1'b0;
                        r_state   <= ST_IDLE;
                        if (!r_pwrite && !pslverr) begin
                            r_rdata <= prdata;
                        end
                    end else if (w_expired) begin
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                        r_penable <= 1'b0;
                        r_psel1   <= 1'b0;
                        r_psel2   <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // A new command overrides the return to IDLE, giving back-to-back transfers.
            if (w_latch) begin
                r_state   <= ST_SETUP;
                r_pwrite  <= (read_write == WRITE);
                r_paddr   <= w_cmd_addr;
                r_pwdata  <= apb_write_data;
                r_psel1   <= ~w_cmd_addr[AW-1];
                r_psel2   <= w_cmd_addr[AW-1];
                r_penable <= 1'b0;
            end
        end
    end

    assign apb_read_data_out = r_rdata;
    assign xfer_done         = r_done;
    assign xfer_err          = r_err;
    assign psel1             = r_psel1;
    assign psel2             = r_psel2;
    assign penable           = r_penable;
    assign pwrite            = r_pwrite;
    assign paddr             = r_paddr;
    assign pwdata            = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, hand sequences, and random transfers against a transaction-level model.
module tb_apb_master_bridge;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int MAX_WAIT = 16;

    logic          pclk;
    logic          presetn;
    logic          transfer;
    logic          read_write;
    logic [AW-1:0] apb_write_paddr;
    logic [AW-1:0] apb_read_paddr;
    logic [DW-1:0] apb_write_data;
    logic [DW-1:0] apb_read_data_out;
    logic          xfer_done;
    logic          xfer_err;
    logic          psel1;
    logic          psel2;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    int n_cmp;
    int n_fail;
    logic [DW-1:0] model_rdata;

    apb_master_bridge #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .pclk              (pclk),
        .presetn           (presetn),
        .transfer          (transfer),
        .read_write        (read_write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_read_paddr    (apb_read_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_data_out (apb_read_data_out),
        .xfer_done         (xfer_done),
        .xfer_err          (xfer_err),
        .psel1             (psel1),
        .psel2             (psel2),
        .penable           (penable),
        .pwrite            (pwrite),
        .paddr             (paddr),
        .pwdata            (pwdata),
        .pready            (pready),
        .prdata            (prdata),
        .pslverr           (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rw;
        logic [8:0]  addr;
        logic [7:0]  wd;
        int          nwait;
        bit          serr;
        logic [7:0]  prd;
        bit          e_psel2;
        bit          e_err;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, " psel1"}, 32'(psel1), 32'(0));
        chk({tag, " psel2"}, 32'(psel2), 32'(0));
        chk({tag, " penable"}, 32'(penable), 32'(0));
        chk({tag, " done"}, 32'(xfer_done), 32'(0));
    endtask

    // One complete transfer from IDLE; nwait >= MAX_WAIT means the slave never answers.
    task automatic run_txn(input bit rw, input logic [8:0] addr, input logic [7:0] wd,
                           input int nwait, input bit serr, input logic [7:0] prd,
                           input bit e_psel2, input bit e_err, input logic [7:0] e_rdata);
        bit timeout;
        int n_access;
        timeout  = (nwait >= MAX_WAIT);
        n_access = timeout ? MAX_WAIT : nwait + 1;

        @(negedge pclk);
        transfer   = 1'b1;
        read_write = rw;
        if (rw) begin
            apb_read_paddr  = addr;
            apb_write_paddr = ~addr;
        end else begin
            apb_write_paddr = addr;
            apb_read_paddr  = ~addr;
        end
        apb_write_data = wd;
        pready  = 1'b0;
        pslverr = 1'b0;

        @(negedge pclk);
        chk("setup psel1", 32'(psel1), 32'(!e_psel2));
        chk("setup psel2", 32'(psel2), 32'(e_psel2));
        chk("setup penable", 32'(penable), 32'(0));
        chk("setup pwrite", 32'(pwrite), 32'(!rw));
        chk("setup paddr", 32'(paddr), 32'(addr));
        chk("setup pwdata", 32'(pwdata), 32'(wd));
        chk("setup done", 32'(xfer_done), 32'(0));
        // Held-high transfer and scrambled command inputs must be ignored here.
        read_write      = ~rw;
        apb_write_paddr = 9'($urandom);
        apb_read_paddr  = 9'($urandom);
        apb_write_data  = 8'($urandom);

        for (int i = 0; i < n_access; i++) begin
            @(negedge pclk);
            chk("access penable", 32'(penable), 32'(1));
            chk("access psel1", 32'(psel1), 32'(!e_psel2));
            chk("access psel2", 32'(psel2), 32'(e_psel2));
            chk("access paddr", 32'(paddr), 32'(addr));
            chk("access pwrite", 32'(pwrite), 32'(!rw));
            chk("access pwdata", 32'(pwdata), 32'(wd));
            chk("access done", 32'(xfer_done), 32'(0));
            if (i == n_access - 1) begin
                transfer = 1'b0;
                pready   = !timeout;
                pslverr  = timeout ? 1'b0 : serr;
                prdata   = prd;
            end else begin
                transfer = 1'b1;
                pready   = 1'b0;
                pslverr  = 1'($urandom);
                prdata   = 8'($urandom);
            end
        end

        @(negedge pclk);
        chk("done pulse", 32'(xfer_done), 32'(1));
        chk("done err", 32'(xfer_err), 32'(e_err));
        chk("done rdata", 32'(apb_read_data_out), 32'(e_rdata));
        chk("done penable", 32'(penable), 32'(0));
        chk("done psel1", 32'(psel1), 32'(0));
        chk("done psel2", 32'(psel2), 32'(0));
        pready  = 1'b0;
        pslverr = 1'b0;
    endtask

    initial begin
        bit          rw;
        logic [8:0]  addr;
        logic [7:0]  wd;
        logic [7:0]  prd;
        int          nwait;
        bit          serr;
        bit          e_err;
        logic [7:0]  e_rdata;

        n_cmp = 0;
        n_fail = 0;
        presetn = 1'b0;
        transfer = 1'b0;
        read_write = 1'b0;
        apb_write_paddr = '0;
        apb_read_paddr = '0;
        apb_write_data = '0;
        pready = 1'b0;
        prdata = '0;
        pslverr = 1'b0;

        tbl[0] = '{1'b0, 9'h012, 8'hA5, 0,  1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 9'h105, 8'h00, 0,  1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C};
        tbl[2] = '{1'b1, 9'h020, 8'h00, 3,  1'b0, 8'h5A, 1'b0, 1'b0, 8'h5A};
        tbl[3] = '{1'b1, 9'h1FF, 8'h00, 1,  1'b1, 8'h77, 1'b1, 1'b1, 8'h5A};
        tbl[4] = '{1'b0, 9'h100, 8'h11, 0,  1'b1, 8'h22, 1'b1, 1'b1, 8'h5A};
        tbl[5] = '{1'b1, 9'h0AA, 8'h00, 16, 1'b0, 8'h99, 1'b0, 1'b1, 8'h5A};
        tbl[6] = '{1'b1, 9'h0AB, 8'h00, 15, 1'b0, 8'hC3, 1'b0, 1'b0, 8'hC3};

        repeat (2) @(negedge pclk);
        chk_idle_bus("reset");
        chk("reset err", 32'(xfer_err), 32'(0));
        chk("reset pwrite", 32'(pwrite), 32'(0));
        chk("reset paddr", 32'(paddr), 32'(0));
        chk("reset pwdata", 32'(pwdata), 32'(0));
        chk("reset rdata", 32'(apb_read_data_out), 32'(0));
        presetn = 1'b1;

        for (int k = 0; k < 7; k++) begin
            run_txn(tbl[k].rw, tbl[k].addr, tbl[k].wd, tbl[k].nwait, tbl[k].serr,
                    tbl[k].prd, tbl[k].e_psel2, tbl[k].e_err, tbl[k].e_rdata);
        end
        model_rdata = 8'hC3;

        // Back-to-back: write 0x001 then read 0x101 with transfer held high.
        @(negedge pclk);
        transfer = 1'b1; read_write = 1'b0;
        apb_write_paddr = 9'h001; apb_write_data = 8'hE7; pready = 1'b0;
        @(negedge pclk);
        chk("b2b setup1 psel1", 32'(psel1), 32'(1));
        chk("b2b setup1 penable", 32'(penable), 32'(0));
        @(negedge pclk);
        chk("b2b access1 penable", 32'(penable), 32'(1));
        read_write = 1'b1; apb_read_paddr = 9'h101; pready = 1'b1; prdata = 8'hFF;
        @(negedge pclk);
        chk("b2b done1", 32'(xfer_done), 32'(1));
        chk("b2b err1", 32'(xfer_err), 32'(0));
        chk("b2b gap penable", 32'(penable), 32'(0));
        chk("b2b setup2 psel1", 32'(psel1), 32'(0));
        chk("b2b setup2 psel2", 32'(psel2), 32'(1));
        chk("b2b setup2 paddr", 32'(paddr), 32'(9'h101));
        chk("b2b setup2 pwrite", 32'(pwrite), 32'(0));
        chk("b2b rdata kept", 32'(apb_read_data_out), 32'(model_rdata));
        transfer = 1'b0; pready = 1'b0;
        @(negedge pclk);
        chk("b2b access2 penable", 32'(penable), 32'(1));
        chk("b2b access2 done", 32'(xfer_done), 32'(0));
        pready = 1'b1; prdata = 8'h4B;
        @(negedge pclk);
        chk("b2b done2", 32'(xfer_done), 32'(1));
        chk("b2b rdata", 32'(apb_read_data_out), 32'(8'h4B));
        chk("b2b end psel2", 32'(psel2), 32'(0));
        pready = 1'b0;
        model_rdata = 8'h4B;

        // Asynchronous reset in the middle of a waited ACCESS phase.
        @(negedge pclk);
        transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h150;
        @(negedge pclk);
        transfer = 1'b0;
        chk("rst pre psel2", 32'(psel2), 32'(1));
        @(negedge pclk);
        chk("rst pre penable", 32'(penable), 32'(1));
        @(negedge pclk);
        #3 presetn = 1'b0;
        #1;
        chk_idle_bus("async rst");
        chk("async rst err", 32'(xfer_err), 32'(0));
        chk("async rst paddr", 32'(paddr), 32'(0));
        chk("async rst rdata", 32'(apb_read_data_out), 32'(0));
        @(posedge pclk);
        #2 presetn = 1'b1;
        model_rdata = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            chk_idle_bus("post rst idle");
        end

        for (int k = 0; k < 40; k++) begin
            rw    = 1'($urandom);
            addr  = 9'($urandom);
            wd    = 8'($urandom);
            prd   = 8'($urandom);
            nwait = ($urandom_range(0, 9) == 0) ? MAX_WAIT : int'($urandom_range(0, 4));
            serr  = ($urandom_range(0, 7) == 0);
            e_err = (nwait >= MAX_WAIT) || serr;
            e_rdata = (rw && !e_err) ? prd : model_rdata;
            run_txn(rw, addr, wd, nwait, serr, prd, addr[8], e_err, e_rdata);
            model_rdata = e_rdata;
        end

        @(negedge pclk);
        chk_idle_bus("final idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts the command-level request from the testbench/driver interface into APB3 protocol for two slaves.
- Request side: transfer, read_write, write/read address, write data. Response side: read data, completion pulse, error flag.
- Sits directly downstream of the driver interface and upstream of the two APB slaves.
- Slave select is decoded from the address MSB: 0 selects slave 1, 1 selects slave 2.

Parameters:
- AW, 9, address width; bit AW-1 is the slave-select bit.
- DW, 8, data width.
- MAX_WAIT, 16, maximum ACCESS cycles with pready low before the transfer is aborted with an error.

Ports:
- pclk  input  1  APB clock; all logic on the rising edge.
- presetn  input  1  asynchronous active-low reset.
- transfer  input  1  request a transfer; sampled in IDLE and on ACCESS completion.
- read_write  input  1  1 = read, 0 = write.
- apb_write_paddr  input  AW  address used when read_write=0.
- apb_read_paddr  input  AW  address used when read_write=1.
- apb_write_data  input  DW  write data.
- apb_read_data_out  output  DW  last completed read data.
- xfer_done  output  1  one-cycle pulse when a transfer completes (normally or by timeout).
- xfer_err  output  1  valid with xfer_done; 1 = pslverr or timeout.
- psel1  output  1  APB select, slave 1.
- psel2  output  1  APB select, slave 2.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction, 1 = write.
- paddr  output  AW  APB address.
- pwdata  output  DW  APB write data.
- pready  input  1  OR of both slaves' pready, qualified by select.
- prdata  input  DW  muxed slave read data.
- pslverr  input  1  slave error.

Behaviour:
- Reset (presetn low, asynchronous): state=IDLE; psel1, psel2, penable, pwrite, xfer_done, xfer_err = 0; paddr, pwdata, apb_read_data_out = 0; wait counter = 0.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - psel*=0, penable=0.
  - If transfer=1 at the edge, latch the command and go to SETUP.
  - Latched command: pwrite = ~read_write; paddr = read_write ? apb_read_paddr : apb_write_paddr; pwdata = apb_write_data (latched regardless of direction).
- SETUP:
  - Exactly one psel is high, chosen by paddr[AW-1]; penable=0.
  - Unconditionally go to ACCESS next cycle; wait counter cleared.
- ACCESS:
  - penable=1; psel, paddr, pwrite, pwdata held stable.
  - pready=1 completes the transfer:
    - xfer_done pulses in the next cycle; xfer_err = pslverr.
    - On a read without pslverr, apb_read_data_out <= prdata. On a read with pslverr, apb_read_data_out holds its old value.
    - If transfer=1 at that edge, latch the new command and go to SETUP (back-to-back; penable drops for one cycle, psel may switch slaves).
    - Otherwise go to IDLE.
  - pready=0: the wait counter increments. When the counter reaches MAX_WAIT-1 with pready still 0, abort: xfer_done=1, xfer_err=1, go to IDLE, apb_read_data_out unchanged.
- Minimum latency: transfer sampled at edge N → SETUP in cycle N+1 → ACCESS in N+2 → xfer_done at N+3 when pready=1 in the first ACCESS cycle.
- transfer and inputs are ignored in SETUP and in non-completing ACCESS cycles.
- psel1 and psel2 are never high together.
- Reset mid-transfer immediately returns to IDLE with all outputs zero. No completion pulse is generated.

Decomposition:
- Package apb_bridge_pkg: AW/DW default constants, state enum typedef (IDLE, SETUP, ACCESS), READ=1 / WRITE=0 constants.
- Optional sub-module apb_wait_timer: wait counter with clear, enable, and expired output. All other logic stays in one module.

Test Plan:
- Write to slave 1: transfer=1, read_write=0, write addr=0x012, data=0xA5, pready=1 → SETUP: psel1=1, paddr=0x012, pwrite=1, pwdata=0xA5, penable=0. Next cycle penable=1. xfer_done=1, xfer_err=0 at N+3.
- Read from slave 2: read addr=0x105, prdata=0x3C, pready=1 → psel2=1, pwrite=0, apb_read_data_out=0x3C, xfer_err=0.
- Wait states: read from 0x020 with pready low for 3 ACCESS cycles → penable and address stable for 4 ACCESS cycles; single xfer_done after pready rises.
- Back-to-back with transfer held high: write 0x001 then read 0x101 → penable low for exactly one cycle between transfers, psel switches from 1 to 2, two xfer_done pulses.
- Error and timeout:
  - pslverr=1 with pready → xfer_err=1, read data not updated.
  - pready held low → abort after 16 ACCESS cycles with xfer_err=1, state returns to IDLE.
- Async reset: assert presetn=0 during ACCESS (not clock-aligned) → psel*, penable, xfer_done drop to 0 immediately. After release, an idle bus is held until transfer=1.
